// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the ID/EX register, the execute ALU and the EX/MEM register.
// The master side issues operations and the slave side (the ALU) returns results.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alu_ctr, src_a, src_b, flush,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, alu_ctr, src_a, src_b, flush,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus an iterative shift-add multiply
// that holds off new issues through in_ready while it runs.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_unit_if.slave    bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state_q, state_d;
  logic               in_ready_c;
  logic               accept_c;
  logic               mul_last_c;

  logic [WIDTH-1:0]   sum_c, diff_c, alu_res_c, mul_step_c;
  logic               alu_ovf_c;

  logic [WIDTH-1:0]   mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q, zero_q, overflow_q;
  logic [WIDTH-1:0]   result_q;

  assign accept_c   = bus.in_valid & in_ready_c & ~bus.flush;
  assign mul_last_c = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c && (bus.alu_ctr == OP_MUL)) state_d = S_MUL;
      S_MUL:   if (bus.flush || mul_last_c)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready_c = 1'b0;
    if (state_q == S_IDLE) in_ready_c = 1'b1;
  end

  // Single-cycle operation datapath; illegal codes fall through to zero
  always_comb begin
    sum_c     = bus.src_a + bus.src_b;
    diff_c    = bus.src_a - bus.src_b;
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (bus.alu_ctr)
      OP_AND: alu_res_c = bus.src_a & bus.src_b;
      OP_OR:  alu_res_c = bus.src_a | bus.src_b;
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                    (sum_c[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                    (diff_c[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      OP_SLT: alu_res_c[0] = ($signed(bus.src_a) < $signed(bus.src_b));
      OP_NOR: alu_res_c = ~(bus.src_a | bus.src_b);
      default: ;
    endcase
  end

  assign mul_step_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept_c && (bus.alu_ctr == OP_MUL)) begin
          mcand_q  <= bus.src_a;
          mplier_q <= bus.src_b;
          acc_q    <= '0;
          cnt_q    <= '0;
        end else if (accept_c) begin
          out_valid_q <= 1'b1;
          result_q    <= alu_res_c;
          zero_q      <= (alu_res_c == '0);
          overflow_q  <= alu_ovf_c;
        end
      end else if (bus.flush) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q    <= mul_step_c;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (mul_last_c) begin
          out_valid_q <= 1'b1;
          result_q    <= mul_step_c;
          zero_q      <= (mul_step_c == '0);
          overflow_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_MUL = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: evaluate the op with wide signed/unsigned integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ovf);
    longint sa, sb, s;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    ovf = 1'b0;
    case (op)
      C_AND: r = a & b;
      C_OR:  r = a | b;
      C_NOR: r = ~(a | b);
      C_ADD: begin s = sa + sb; r = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_SUB: begin s = sa - sb; r = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      C_SLT: r = (sa < sb) ? 1 : 0;
      C_MUL: begin p = {32'd0, a} * {32'd0, b}; r = W'(p); end
      default: r = '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic f);
    bus.in_valid = v;
    bus.alu_ctr  = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.flush    = f;
  endtask

  task automatic test_reset();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 ||
        bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b ov=%b res=%h z=%b of=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow);
    end
  endtask

  task automatic test_add_overflow();
    drive(1'b1, C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h8000_0000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: ov=%b res=%h of=%b z=%b, required 1 80000000 1 0",
               bus.out_valid, bus.result, bus.overflow, bus.zero);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h8000_0000 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL add_hold: ov=%b res=%h of=%b, required 0 80000000 1",
               bus.out_valid, bus.result, bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [3] = '{C_SUB, C_SLT, C_NOR};
    logic [W-1:0] as  [3] = '{32'd5, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] bs  [3] = '{32'd5, 32'h0000_0001, 32'd0};
    logic [W-1:0] exp [3] = '{32'd0, 32'd1, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b, required 1", i, bus.in_ready);
      end
      drive(1'b1, ops[i], as[i], bs[i], 1'b0);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i] || bus.zero !== (exp[i] == '0)) begin
        errors++;
        $display("FAIL b2b[%0d]: ov=%b res=%h z=%b, required 1 %h %b",
                 i, bus.out_valid, bus.result, bus.zero, exp[i], (exp[i] == '0));
      end
    end
    drive(1'b0, C_AND, '0, '0, 1'b0);
  endtask

  task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    int busy_bad = 0;
    drive(1'b1, C_MUL, a, b, 1'b0);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    for (int i = 1; i <= int'(W); i++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_bad++;
      tick();
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL mul_busy: %0d busy cycles with in_ready/out_valid wrong, required 0", busy_bad);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== exp || bus.in_ready !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mul_result: ov=%b res=%h rdy=%b of=%b, required 1 %h 1 0",
               bus.out_valid, bus.result, bus.in_ready, bus.overflow, exp);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse: out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    drive(1'b1, C_MUL, 32'd1000, 32'd1000, 1'b0);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    repeat (9) tick();
    drive(1'b1, C_ADD, 32'd1, 32'd1, 1'b1);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: rdy=%b ov=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL flush_no_out: %0d out_valid pulses, required 0", pulses);
    end
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, C_ADD, 32'd40, 32'd2, 1'b0);
    tick();
    drive(1'b1, C_MUL, 32'd77, 32'd99, 1'b0);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 ||
        bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_mul: rdy=%b ov=%b res=%h z=%b of=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.overflow);
    end
    drive(1'b1, C_ADD, 32'd2, 32'd3, 1'b0);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd5) begin
      errors++;
      $display("FAIL rst_then_add: ov=%b res=%h, required 1 5", bus.out_valid, bus.result);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, C_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
    tick();
    drive(1'b1, 4'b0101, 32'd7, 32'd0, 1'b0);
    tick();
    drive(1'b0, C_AND, '0, '0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== '0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL illegal: ov=%b res=%h z=%b of=%b, required 1 0 1 0",
               bus.out_valid, bus.result, bus.zero, bus.overflow);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 16));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [W-1:0] a, b, er, last_r;
    logic [3:0]   op;
    logic         eo, last_o;
    int           sel, lat;
    last_r = bus.result;
    last_o = bus.overflow;
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 9));
      a = pick_operand();
      b = pick_operand();
      if (sel == 0) begin
        drive(1'b0, C_ADD, a, b, 1'b0);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== last_r || bus.overflow !== last_o) begin
          errors++;
          $display("FAIL rnd_idle[%0d]: ov=%b res=%h of=%b, required 0 %h %b",
                   i, bus.out_valid, bus.result, bus.overflow, last_r, last_o);
        end
      end else begin
        if (sel == 1) op = C_MUL;
        else begin
          op = 4'($urandom_range(0, 15));
          if (op == C_MUL) op = C_ADD;
        end
        model(op, a, b, er, eo);
        drive(1'b1, op, a, b, 1'b0);
        tick();
        drive(1'b0, C_AND, '0, '0, 1'b0);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < int'(W) + 4) begin
          tick();
          lat++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || lat != ((op == C_MUL) ? int'(W) + 1 : 1) ||
            bus.result !== er || bus.overflow !== eo || bus.zero !== (er == '0)) begin
          errors++;
          $display("FAIL rnd_op[%0d] op=%b a=%h b=%h: ov=%b lat=%0d res=%h of=%b z=%b, required res=%h of=%b",
                   i, op, a, b, bus.out_valid, lat, bus.result, bus.overflow, bus.zero, er, eo);
        end
        last_r = er;
        last_o = eo;
      end
    end
  endtask

  initial begin
    drive(1'b0, C_AND, '0, '0, 1'b0);
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mul(32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    test_mul(32'd12345, 32'd678, 32'd8369910);
    test_flush();
    test_reset_mid_mul();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
